// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with runtime baud divisor, a
// 2-flop input synchroniser, optional parity, 1 or 2 stop bits, per-word
// parity/framing flags and a small output FIFO with a valid/ready handshake.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous active-high reset
//   in          asynchronous serial line, idle high
//   baud_div    clocks per bit, latched at frame start, clamped to >= 4
//   out         FIFO head word, LSB = first data bit received
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts the head word when out_valid & out_ready
//   parity_err  head word parity mismatch flag
//   frame_err   head word flag: a stop bit was sampled low
//   overrun     one-cycle pulse when a completed word is dropped (FIFO full)
module uart_rx_cfg #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in,
  input  logic [15:0]          baud_div,
  output logic [DATA_BITS-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam int unsigned WORD_W = DATA_BITS + 2;

  localparam logic [CNT_W-1:0] MIN_DIV    = CNT_W'(4);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_BITS - 1);
  localparam logic [OCC_W-1:0] FULL_OCC   = OCC_W'(FIFO_DEPTH);
  localparam logic             ODD_PARITY = 1'(PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_STOP2
  } state_t;

  state_t state, state_next;

  logic [1:0]           sync_q;
  logic                 sync;
  logic                 armed;
  logic [CNT_W-1:0]     div;
  logic [CNT_W-1:0]     half;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q;
  logic                 stop_low;
  logic                 hit_half;
  logic                 hit_full;
  logic                 frame_bad;

  logic start_frame, shift_en, par_en, stop_en, frame_done;

  assign sync      = sync_q[1];
  assign half      = div >> 1;
  assign hit_half  = (cnt == half - CNT_W'(1));
  assign hit_full  = (cnt == div - CNT_W'(1));
  // Framing flag for the word being completed, including the current stop sample.
  assign frame_bad = stop_low | ~sync;

  // Input synchroniser; resets to the idle-high line level.
  always_ff @(posedge clock) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], in};
  end

  // Start gate: a bad frame disarms until the line has been seen high again.
  always_ff @(posedge clock) begin
    if (reset)                        armed <= 1'b0;
    else if (frame_done && frame_bad) armed <= 1'b0;
    else if (sync)                    armed <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM next-state and datapath strobes.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    stop_en     = 1'b0;
    frame_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (armed && !sync) begin
          state_next  = S_START;
          start_frame = 1'b1;
        end
      end
      S_START: begin
        // A line that is high again at mid-start-bit was a glitch.
        if (hit_half) state_next = sync ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (hit_full) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_next = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (hit_full) begin
          par_en     = 1'b1;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (hit_full) begin
          stop_en = 1'b1;
          if (STOP_BITS == 2) begin
            state_next = S_STOP2;
          end else begin
            frame_done = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      S_STOP2: begin
        if (hit_full) begin
          stop_en    = 1'b1;
          frame_done = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Bit timing, divisor latch, shift register and per-frame flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      div      <= MIN_DIV;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      stop_low <= 1'b0;
    end else begin
      // Counter restarts on every state entry and after each data sample.
      if (state == S_IDLE || state_next != state || shift_en) cnt <= '0;
      else                                                    cnt <= cnt + CNT_W'(1);
      if (start_frame) begin
        div      <= (baud_div < MIN_DIV) ? MIN_DIV : baud_div;
        bit_cnt  <= '0;
        par_q    <= 1'b0;
        stop_low <= 1'b0;
      end
      if (shift_en) begin
        shreg   <= {sync, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
      if (par_en)             par_q    <= ((^shreg) ^ sync) != ODD_PARITY;
      if (stop_en && !sync)   stop_low <= 1'b1;
    end
  end

  // Output FIFO.
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [WORD_W-1:0] push_word;
  logic [WORD_W-1:0] head_next;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_next;
  logic [OCC_W-1:0]  occ, occ_after_pop, occ_next;
  logic              pop, full, push_ok, drop;

  assign push_word     = {shreg, par_q, frame_bad};
  assign pop           = out_valid & out_ready;
  assign full          = (occ == FULL_OCC);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok       = frame_done & (~full | pop);
  assign drop          = frame_done & full & ~pop;
  assign occ_after_pop = occ - OCC_W'(pop);
  assign occ_next      = occ_after_pop + OCC_W'(push_ok);
  assign rd_next       = rd_ptr + PTR_W'(pop);
  // The incoming word becomes the head only if nothing older remains.
  assign head_next     = (push_ok && occ_after_pop == '0) ? push_word : mem[rd_next];

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  // FIFO pointers and registered head/flags; head holds its value when empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      out        <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr    <= rd_next;
      occ       <= occ_next;
      out_valid <= (occ_next != '0);
      overrun   <= drop;
      if (occ_next != '0) {out, parity_err, frame_err} <= head_next;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three instances (8N1, 8E1, 7O2) are
// driven with directed and random frames; expected words are queued when a
// frame is issued and a negedge monitor pops and compares on each handshake.
module tb_uart_rx_cfg;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  line;
  logic [2:0]  rdy;
  logic [15:0] baud [3];
  logic [7:0]  out0, out1;
  logic [6:0]  out2;
  logic [2:0]  ov, pe, fe, ovr;

  always #5 clk = ~clk;

  uart_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clock(clk), .reset(reset), .in(line[0]), .baud_div(baud[0]), .out(out0),
    .out_valid(ov[0]), .out_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]),
    .overrun(ovr[0]));

  uart_rx_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .clock(clk), .reset(reset), .in(line[1]), .baud_div(baud[1]), .out(out1),
    .out_valid(ov[1]), .out_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]),
    .overrun(ovr[1]));

  uart_rx_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(2)) dut2 (
    .clock(clk), .reset(reset), .in(line[2]), .baud_div(baud[2]), .out(out2),
    .out_valid(ov[2]), .out_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]),
    .overrun(ovr[2]));

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t expq [3][$];
  int   checks = 0;
  int   errors = 0;
  int   recv_cnt [3];
  int   ovr_seen [3];
  int   exp_ovr  [3];

  function automatic int nbits(input int idx);
    return (idx == 2) ? 7 : 8;
  endfunction
  function automatic int pmode(input int idx);
    return idx;
  endfunction
  function automatic int nstop(input int idx);
    return (idx == 2) ? 2 : 1;
  endfunction
  function automatic int depth(input int idx);
    return (idx == 2) ? 2 : 4;
  endfunction

  // Parity bit that makes the frame correct for the instance's mode.
  function automatic logic good_pbit(input int idx, input logic [8:0] data);
    logic [8:0] dm;
    int ones;
    dm   = data & ((9'd1 << nbits(idx)) - 9'd1);
    ones = $countones(dm);
    if (pmode(idx) == 1) return 1'((ones % 2) == 1);
    if (pmode(idx) == 2) return 1'((ones % 2) == 0);
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mon(input int idx, input logic [8:0] d, input logic v, input logic r,
                     input logic p, input logic f, input logic o);
    exp_t e;
    if (o === 1'b1) ovr_seen[idx]++;
    if (v === 1'b1 && r === 1'b1) begin
      recv_cnt[idx]++;
      checks++;
      if (expq[idx].size() == 0) begin
        errors++;
        $display("FAIL dut%0d unexpected word: got data=0x%0h pe=%0b fe=%0b expected no word",
                 idx, d, p, f);
      end else begin
        e = expq[idx].pop_front();
        if (d !== e.data || p !== e.pe || f !== e.fe) begin
          errors++;
          $display("FAIL dut%0d word: got data=0x%0h pe=%0b fe=%0b expected data=0x%0h pe=%0b fe=%0b",
                   idx, d, p, f, e.data, e.pe, e.fe);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      mon(0, 9'(out0), ov[0], rdy[0], pe[0], fe[0], ovr[0]);
      mon(1, 9'(out1), ov[1], rdy[1], pe[1], fe[1], ovr[1]);
      mon(2, 9'(out2), ov[2], rdy[2], pe[2], fe[2], ovr[2]);
    end
  end

  // Issue one frame; the expected word (or an expected drop) is recorded first.
  task automatic send(input int idx, input logic [8:0] data, input int bd, input logic pbit,
                      input logic [1:0] bad_stop, input int gap, input bit scramble);
    int         d;
    int         ones;
    logic       odd_total;
    logic [8:0] dm;
    exp_t       e;
    d         = (bd < 4) ? 4 : bd;
    dm        = data & ((9'd1 << nbits(idx)) - 9'd1);
    ones      = $countones(dm);
    odd_total = 1'(((ones + int'(pbit)) % 2) == 1);
    e.data    = dm;
    e.pe      = (pmode(idx) != 0) && (odd_total != (pmode(idx) == 2));
    e.fe      = bad_stop[0] || (nstop(idx) == 2 && bad_stop[1]);
    if (!rdy[idx] && expq[idx].size() >= depth(idx)) exp_ovr[idx]++;
    else expq[idx].push_back(e);
    baud[idx] = 16'(bd);
    line[idx] = 1'b0;
    tick(d);
    if (scramble) baud[idx] = 16'($urandom_range(0, 40));
    for (int i = 0; i < nbits(idx); i++) begin
      line[idx] = dm[i];
      tick(d);
    end
    if (pmode(idx) != 0) begin
      line[idx] = pbit;
      tick(d);
    end
    for (int s = 0; s < nstop(idx); s++) begin
      line[idx] = ~bad_stop[s];
      tick(d);
    end
    if (gap > 0) begin
      line[idx] = 1'b1;
      tick(gap * d);
    end
  endtask

  task automatic drain(input int idx, input string name);
    int t;
    t = 0;
    while (expq[idx].size() != 0 && t < 3000) begin
      tick(1);
      t++;
    end
    tick(2);
    chk(name, 32'(expq[idx].size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " out0"}, 32'(out0), 32'd0);
    chk({tag, " out1"}, 32'(out1), 32'd0);
    chk({tag, " out2"}, 32'(out2), 32'd0);
    chk({tag, " out_valid"}, 32'(ov), 32'd0);
    chk({tag, " parity_err"}, 32'(pe), 32'd0);
    chk({tag, " frame_err"}, 32'(fe), 32'd0);
    chk({tag, " overrun"}, 32'(ovr), 32'd0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq [4];
    int r0, r2;
    logic [8:0] rd;
    int rb;
    logic [1:0] bad;
    int gap;

    reset = 1'b1;
    line  = 3'b111;
    rdy   = 3'b111;
    for (int i = 0; i < 3; i++) baud[i] = 16'd8;
    tick(3);
    check_reset_vals("reset");
    reset = 1'b0;
    tick(4);
    check_reset_vals("post-reset idle");

    // 8N1 back-to-back frames.
    seq = '{8'h55, 8'hCC, 8'hFF, 8'h33};
    for (int i = 0; i < 4; i++) send(0, 9'(seq[i]), 8, 1'b0, 2'b00, 0, 1'b0);
    drain(0, "8n1 drain");
    chk("8n1 head holds", 32'(out0), 32'h33);
    chk("8n1 valid low when empty", 32'(ov[0]), 32'd0);

    // Even parity: correct then wrong parity bit.
    send(1, 9'h0A5, 16, 1'b0, 2'b00, 1, 1'b0);
    send(1, 9'h0A5, 16, 1'b1, 2'b00, 1, 1'b0);
    drain(1, "parity drain");

    // Break: line held low for 12 bit times, then re-arm.
    r0 = recv_cnt[0];
    expq[0].push_back('{9'd0, 1'b0, 1'b1});
    baud[0] = 16'd8;
    line[0] = 1'b0;
    tick(12 * 8);
    chk("break words while low", 32'(recv_cnt[0] - r0), 32'd1);
    line[0] = 1'b1;
    tick(16);
    send(0, 9'h03C, 8, 1'b0, 2'b00, 1, 1'b0);
    drain(0, "break rearm drain");
    chk("break total words", 32'(recv_cnt[0] - r0), 32'd2);

    // Overrun with consumer stalled.
    rdy[0] = 1'b0;
    for (int i = 1; i <= 5; i++) send(0, 9'(i), 8, 1'b0, 2'b00, 0, 1'b0);
    tick(16);
    chk("overrun pulses", 32'(ovr_seen[0]), 32'(exp_ovr[0]));
    chk("overrun head", 32'(out0), 32'h01);
    chk("overrun valid", 32'(ov[0]), 32'd1);
    rdy[0] = 1'b1;
    drain(0, "overrun drain");

    // Two-cycle glitch produces nothing.
    r0 = recv_cnt[0];
    baud[0] = 16'd8;
    line[0] = 1'b0;
    tick(2);
    line[0] = 1'b1;
    tick(40);
    chk("glitch no word", 32'(recv_cnt[0] - r0), 32'd0);

    // Reset during the data bits of 0x77, then a clean 0x81.
    line[0] = 1'b0;
    tick(8);
    for (int i = 0; i < 3; i++) begin
      line[0] = 1'b1;
      tick(8);
    end
    reset   = 1'b1;
    line[0] = 1'b1;
    tick(2);
    check_reset_vals("mid-frame reset");
    reset = 1'b0;
    tick(8);
    send(0, 9'h081, 8, 1'b0, 2'b00, 1, 1'b0);
    drain(0, "post-reset drain");
    chk("post-reset word count", 32'(recv_cnt[0] - r0), 32'd1);

    // 7O2: second stop low, line stays low, then high and 0x15.
    r2 = recv_cnt[2];
    send(2, 9'h02A, 5, good_pbit(2, 9'h02A), 2'b10, 0, 1'b0);
    tick(15);
    chk("disarmed while low", 32'(recv_cnt[2] - r2), 32'd1);
    line[2] = 1'b1;
    tick(10);
    send(2, 9'h015, 5, good_pbit(2, 9'h015), 2'b00, 1, 1'b0);
    drain(2, "7o2 drain");
    chk("7o2 word count", 32'(recv_cnt[2] - r2), 32'd2);

    // Random frames: divisor (including clamped values), parity bit,
    // stop corruption, gaps and mid-frame divisor changes.
    for (int idx = 0; idx < 3; idx++) begin
      for (int n = 0; n < 8; n++) begin
        rd  = 9'($urandom);
        rb  = $urandom_range(0, 12);
        bad = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        gap = (bad != 2'b00) ? $urandom_range(1, 2) : $urandom_range(0, 2);
        send(idx, rd, rb, 1'($urandom_range(0, 1)), bad, gap, 1'b1);
      end
      line[idx] = 1'b1;
      drain(idx, $sformatf("random drain dut%0d", idx));
    end

    for (int i = 0; i < 3; i++)
      chk($sformatf("final overrun count dut%0d", i), 32'(ovr_seen[i]), 32'(exp_ovr[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver. It succeeds the fixed 8N1 `UART_RX` and adds runtime baud divisor, configurable data width, parity and stop bits, and a 2-flop input synchroniser. It also adds per-word parity and framing error flags and a small output FIFO with a valid/ready handshake. It sits between the serial pin and the byte-stream consumer.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5–9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: output FIFO entries, power of 2, ≥2.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in`  in  1  asynchronous serial line; idle high.
- `baud_div`  in  16  clocks per bit; values <4 are treated as 4.
- `out`  out  DATA_BITS  received word at FIFO head, LSB = first data bit.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head word when `out_valid & out_ready`.
- `parity_err`  out  1  head word's parity mismatch flag; 0 when PARITY = 0.
- `frame_err`  out  1  head word's flag: a stop bit was sampled low.
- `overrun`  out  1  one-cycle pulse when a completed word is dropped because the FIFO is full.

## Operation
- Input passes through 2 flops (`sync`), both reset to 1. All logic uses `sync`.
- `armed` flag: cleared by reset and by any frame ending in frame_err. It sets on any cycle with `sync`=1. A start is accepted only while `armed`=1.
- `baud_div` is latched as `div` (clamped ≥4) on the IDLE→START transition. Changes mid-frame are ignored. `half` = `div`>>1.
- Bit counter `cnt` is 16 bits and resets to 0 on every state entry.
- FSM:
  - IDLE: if `armed` & `sync`=0, go to START.
  - START: sample when `cnt`=`half`−1. If `sync`=0, go to DATA. If `sync`=1 (glitch), go to IDLE with no word and no flag.
  - DATA: sample when `cnt`=`div`−1, shifting LSB-first. After DATA_BITS samples, go to PARITY if PARITY≠0, else STOP.
  - PARITY: sample at `cnt`=`div`−1. `parity_err` = (XOR of data bits XOR sampled bit) ≠ (PARITY==2).
  - STOP: sample at `cnt`=`div`−1. If STOP_BITS=2, the first stop sample moves to STOP2, which samples again the same way. Any low stop sample sets frame_err.
- Frame end, at the last stop-sample cycle:
  - Push {data, parity_err, frame_err} into the FIFO and go to IDLE in the same cycle.
  - The next start can be detected from the following cycle, giving a half-bit resync margin.
- Break condition: all-zero data with stop bit low yields word 0 with frame_err=1, clears `armed`, and no further frame is accepted until the line returns high.
- FIFO:
  - Pop on `out_valid & out_ready`.
  - Push while full with no pop: word dropped, `overrun`=1 for that cycle, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both succeed, no overrun.
  - Empty FIFO: no bypass; `out` holds the last head value, or 0 after reset.

## Timing
- Reset values: `out`=0, `out_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, FSM=IDLE, FIFO empty, `armed`=0, `sync`=2'b11.
- Reset mid-frame aborts the frame; the partial word is discarded and no flag is raised.
- Line-low detection: a line falling at edge k is seen in `sync` at edge k+2, and IDLE→START occurs at k+2.
- Frame end to output: `out_valid` rises 1 cycle after the last stop-sample cycle. `out` and the flags are valid in that same cycle.
- Stop-sample cycle relative to start detection: `half` + (DATA_BITS + (PARITY≠0) + STOP_BITS)·`div` − 1 cycles after START entry.
- Outputs are registered; no combinational path from `in`. `out_ready` affects FIFO state at the next edge only.

## Test plan
- 8N1, `baud_div`=8, `out_ready`=1: send frames 0x55, 0xCC, 0xFF, 0x33 back-to-back with 80-time-unit bits. Expect 4 pops of 0x55, 0xCC, 0xFF, 0x33 with all flags 0.
- PARITY=1, `baud_div`=16: send 0xA5 with parity 0 (correct), then 0xA5 with parity 1. Expect parity_err 0, then 1, with data 0xA5 both times.
- Break and re-arm: hold the line low for 12 bit times. Expect one word 0x00 with frame_err=1 and no further words until the line is high. Then send 0x3C and expect 0x3C with clean flags.
- Overrun: FIFO_DEPTH=4 with `out_ready`=0, send 5 frames 0x01–0x05. Expect `overrun` to pulse once at the 5th stop sample; raising `out_ready` then yields 0x01–0x04.
- Glitch and reset: drive the line low for 2 cycles with `baud_div`=8; expect no word. Assert reset during the DATA bits of 0x77; expect no word, all outputs at reset values, and correct reception of the next frame 0x81.
- STOP_BITS=2, DATA_BITS=7, `baud_div`=5: send 0x2A with the second stop bit low. Expect 0x2A with frame_err=1, and `armed` requiring idle high before the next frame 0x15 is accepted.
